data_memory_responder: RTL and testbench

- Multi-cycle word-addressed data memory. It is the responder end of the processor's load/store interface: the initiator presents address, write data and write enable, and this block returns read data.
- It replaces the zero-latency memory model with a request/ready handshake and a configurable number of wait states, so that stalling load/store logic can be exercised.
- It sits on the data side of the core, alongside the instruction memory.

---
 rtl/data_memory_responder_if.sv | 31 +++
 rtl/data_memory_responder.sv | 123 ++++++++++++
 tb/tb_data_memory_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - load/store request/response bus between initiator and data memory
//
// Signals:
//   req    initiator -> memory  access request, sampled only while the memory is idle
//   we     initiator -> memory  1 = store word, 0 = load word
//   addr   initiator -> memory  byte address
//   wdata  initiator -> memory  store data
//   ready  memory -> initiator  one-cycle completion pulse
//   rdata  memory -> initiator  load result
//   err    memory -> initiator  misaligned-access flag, meaningful while ready=1
//   busy   memory -> initiator  memory is not idle
interface data_memory_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, err, busy
    );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle word-addressed data memory with wait states
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset, released synchronously by the clock
//   bus    slave side of data_memory_responder_if (req/we/addr/wdata in, ready/rdata/err/busy out)
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   LATENCY     extra wait cycles before an access completes (0..15)
module data_memory_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic                  access;
    logic                  aligned;
    logic                  mem_write;
    logic [DEPTH_LOG2-1:0] index;

    // Upper address bits only alias; they never select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, lat_addr[31:DEPTH_LOG2+2]};

    assign index   = lat_addr[DEPTH_LOG2+1:2];
    assign aligned = (lat_addr[1:0] == 2'b00);
    // The access happens on the edge that leaves WAIT.
    assign access  = (state == ST_WAIT) && (cnt == 4'(LATENCY));
    // Qualify with reset so a store caught by reset at the same edge is dropped.
    assign mem_write = reset && access && aligned && lat_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (bus.req) next_state = ST_WAIT;
            ST_WAIT: if (cnt == 4'(LATENCY)) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        lat_we    <= bus.we;
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        cnt       <= 4'd0;
                    end
                end
                ST_WAIT: begin
                    if (access) begin
                        if (!aligned) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                        end else begin
                            // Stores leave rdata holding the last load result.
                            if (!lat_we) rdata_q <= mem[index];
                            err_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[index] <= lat_wdata;
        end
    end

    assign bus.ready = (state == ST_RESP);
    assign bus.busy  = (state != ST_IDLE);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_memory_responder_if bus0 ();
    data_memory_responder_if bus1 ();

    data_memory_responder #(.DEPTH_LOG2(6), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    data_memory_responder #(.DEPTH_LOG2(6), .LATENCY(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    logic        t_req   [2] = '{1'b0, 1'b0};
    logic        t_we    [2] = '{1'b0, 1'b0};
    logic [31:0] t_addr  [2] = '{32'h0, 32'h0};
    logic [31:0] t_wdata [2] = '{32'h0, 32'h0};
    logic        o_ready [2];
    logic        o_busy  [2];
    logic        o_err   [2];
    logic [31:0] o_rdata [2];

    assign bus0.req = t_req[0];   assign bus1.req = t_req[1];
    assign bus0.we = t_we[0];     assign bus1.we = t_we[1];
    assign bus0.addr = t_addr[0]; assign bus1.addr = t_addr[1];
    assign bus0.wdata = t_wdata[0]; assign bus1.wdata = t_wdata[1];
    assign o_ready[0] = bus0.ready; assign o_ready[1] = bus1.ready;
    assign o_busy[0] = bus0.busy;   assign o_busy[1] = bus1.busy;
    assign o_err[0] = bus0.err;     assign o_err[1] = bus1.err;
    assign o_rdata[0] = bus0.rdata; assign o_rdata[1] = bus1.rdata;

    int n_checks = 0;
    int n_fail = 0;
    int edges = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Model: elapsed edges since a request was accepted decide the outputs;
    // the access takes effect LATENCY+1 edges after acceptance.
    int          m_age  [2] = '{-1, -1};
    logic [31:0] m_mem  [2][64];
    logic [31:0] m_rd   [2] = '{32'h0, 32'h0};
    logic        m_rdy  [2] = '{1'b0, 1'b0};
    logic        m_err  [2] = '{1'b0, 1'b0};
    logic        m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_age[i] = -1; m_rd[i] = 32'h0; m_rdy[i] = 1'b0; m_err[i] = 1'b0;
            end
        end else begin
            edges++;
            for (int i = 0; i < 2; i++) begin
                if (m_age[i] < 0) begin
                    if (t_req[i]) begin
                        m_age[i] = 0; m_we[i] = t_we[i]; m_addr[i] = t_addr[i]; m_wd[i] = t_wdata[i];
                    end
                end else begin
                    m_age[i]++;
                    if (m_age[i] == lat_of(i) + 1) begin
                        m_rdy[i] = 1'b1;
                        if (m_addr[i] % 4 != 0) begin
                            m_rd[i] = 32'h0; m_err[i] = 1'b1;
                        end else begin
                            m_err[i] = 1'b0;
                            if (m_we[i]) m_mem[i][(m_addr[i] / 4) % 64] = m_wd[i];
                            else m_rd[i] = m_mem[i][(m_addr[i] / 4) % 64];
                        end
                    end else if (m_age[i] == lat_of(i) + 2) begin
                        m_age[i] = -1; m_rdy[i] = 1'b0; m_err[i] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if ($time > 6) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ready%0d", i), {31'h0, o_ready[i]}, {31'h0, m_rdy[i]});
                chk($sformatf("busy%0d", i), {31'h0, o_busy[i]}, {31'h0, (m_age[i] >= 0)});
                chk($sformatf("err%0d", i), {31'h0, o_err[i]}, {31'h0, m_err[i]});
                chk($sformatf("rdata%0d", i), o_rdata[i], m_rd[i]);
            end
        end
    end

    // One access on DUT id; checks latency, err and rdata against literals.
    task automatic access(input int id, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int n;
        bit seen;
        @(negedge clk); #1;
        t_req[id] = 1'b1; t_we[id] = w; t_addr[id] = a; t_wdata[id] = d;
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (o_ready[id]) seen = 1;
        end
        #1;
        t_req[id] = 1'b0;
        chk($sformatf("lat_%0d_%h", id, a), n, exp_lat);
        chk($sformatf("err_%0d_%h", id, a), {31'h0, o_err[id]}, {31'h0, exp_err});
        chk($sformatf("rd_%0d_%h", id, a), o_rdata[id], exp_rd);
    endtask

    logic [6:0] rdy_trace;
    logic [6:0] busy_trace;
    int ready_count;

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_rdata", o_rdata[0], 32'h0);
        chk("idle_busy", {31'h0, o_busy[0]}, 32'h0);

        // Store then load, LATENCY=2
        access(0, 1, 32'h10, 32'hDEADBEEF, 4, 0, 32'h0);
        access(0, 0, 32'h10, 32'h0, 4, 0, 32'hDEADBEEF);

        // Aliasing
        access(0, 1, 32'h104, 32'h12345678, 4, 0, 32'hDEADBEEF);
        access(0, 1, 32'h008, 32'h0BADF00D, 4, 0, 32'hDEADBEEF);
        access(0, 0, 32'h004, 32'h0, 4, 0, 32'h12345678);
        access(0, 0, 32'h008, 32'h0, 4, 0, 32'h0BADF00D);

        // Misaligned
        access(0, 1, 32'h20, 32'hA5A5A5A5, 4, 0, 32'h0BADF00D);
        access(0, 1, 32'h22, 32'hFFFFFFFF, 4, 1, 32'h0);
        access(0, 0, 32'h20, 32'h0, 4, 0, 32'hA5A5A5A5);
        access(0, 0, 32'h21, 32'h0, 4, 1, 32'h0);

        // LATENCY=0 back-to-back with req held
        access(1, 1, 32'h00, 32'h00000111, 2, 0, 32'h0);
        access(1, 1, 32'h04, 32'h00000444, 2, 0, 32'h0);
        @(negedge clk); #1;
        t_req[1] = 1'b1; t_we[1] = 1'b0; t_addr[1] = 32'h00;
        rdy_trace[0] = o_ready[1]; busy_trace[0] = o_busy[1];
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            rdy_trace[c] = o_ready[1]; busy_trace[c] = o_busy[1];
            if (c == 2) chk("b2b_rd0", o_rdata[1], 32'h00000111);
            if (c == 5) chk("b2b_rd1", o_rdata[1], 32'h00000444);
            #1;
            if (c == 1) t_addr[1] = 32'h04;
            if (c == 2) t_addr[1] = 32'h04;
            if (c == 5) t_req[1] = 1'b0;
        end
        chk("b2b_ready", {25'h0, rdy_trace}, {25'h0, 7'b0100100});
        chk("b2b_busy", {25'h0, busy_trace}, {25'h0, 7'b0110110});

        // Reset mid-operation
        access(0, 1, 32'h30, 32'h11112222, 4, 0, 32'h0);
        @(negedge clk); #1;
        t_req[0] = 1'b1; t_we[0] = 1'b1; t_addr[0] = 32'h30; t_wdata[0] = 32'hCAFEBABE;
        ready_count = 0;
        repeat (2) begin
            @(negedge clk);
            if (o_ready[0]) ready_count++;
        end
        #1 reset = 1'b0;
        t_req[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (o_ready[0]) ready_count++;
        end
        #1 reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_ready[0]) ready_count++;
        end
        chk("abort_no_ready", ready_count, 0);
        access(0, 0, 32'h30, 32'h0, 4, 0, 32'h11112222);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
